// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Optional stats build: define FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set req
// bit strictly after last, wrapping modulo N.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] pick,
  output logic           any_valid
);

  int idx;

  // Scan last+1 .. last+N and keep the first hit.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last) + i;
      if (idx >= N) idx = idx - N;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        pick      = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port.
// Define FIFO_ARB_STATS_EN to add the stall_cnt output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [id_w(NUM_REQ)-1:0]  grant_id,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int IDW = id_w(NUM_REQ);
  localparam int CW  = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] LAST_BEAT =
    CW'(BURST_MAX - 1);
  localparam logic [IDW-1:0] LAST_INIT =
    IDW'(NUM_REQ - 1);

  arb_state_t     state, state_n;
  logic [IDW-1:0] gid_n;
  logic [IDW-1:0] last_grant, last_n;
  logic [CW-1:0]  beat_cnt, cnt_n;
  logic [IDW-1:0] pick;
  logic           any_valid;
  logic           g_valid;
  logic           beat;

  fifo_rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .req       (req_valid),
    .last      (last_grant),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign g_valid    = req_valid[grant_id];
  assign busy       = (state == ST_GRANT);
  assign beat       = busy && g_valid && !fifo_full;
  assign fifo_wr_en = beat;

  // Only the granted producer sees ready, and only when room.
  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  // Write data always follows the current grant.
  always_comb begin
    fifo_data_in = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k))
        fifo_data_in = req_data[k*DATA_W +: DATA_W];
    end
  end

  // Arbitration and burst-release decisions.
  always_comb begin
    state_n = state;
    gid_n   = grant_id;
    last_n  = last_grant;
    cnt_n   = beat_cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_valid) begin
          gid_n   = pick;
          cnt_n   = '0;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!g_valid) begin
          state_n = ST_IDLE;
          last_n  = grant_id;
        end else if (beat) begin
          cnt_n = beat_cnt + CW'(1);
          if (beat_cnt == LAST_BEAT) begin
            state_n = ST_IDLE;
            last_n  = grant_id;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register; last_grant starts at the top id.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= gid_n;
      last_grant <= last_n;
      beat_cnt   <= cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating count of cycles blocked by a full FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (busy && g_valid && fifo_full &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
